// File: rtl/raster_pkg.sv
`default_nettype none
// ============================================================================
// Module      : raster_pkg
// Description : Shared state encoding and default widths for the raster
//               address generator.
// Revision    : 1.0 - initial release
// ============================================================================
package raster_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_X_W    = 10;
  localparam int DEF_Y_W    = 10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/raster_addr_gen_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Up-counter with synchronous clear, increment enable and a
//               programmable terminal count; rolls over to zero after tc.
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] tc,
  output logic [W-1:0] count,
  output logic         at_tc
);

  import raster_pkg::*;

  logic [W-1:0] r_count;

  // Clear has priority over increment; increment at terminal count rolls over.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= at_tc ? '0 : r_count + W'(1);
    end
  end

  assign count = r_count;
  assign at_tc = (r_count == tc);

endmodule
`default_nettype wire

// File: rtl/raster_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : raster_addr_gen
// Description : 2-D raster address generator. Walks a width x height window
//               with a row stride from a base address, one address per
//               accepted valid/ready beat, with row/frame markers, optional
//               continuous wrap and abort.
// Revision    : 1.0 - initial release
// ============================================================================
module raster_addr_gen
  import raster_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int X_W    = DEF_X_W,
  parameter int Y_W    = DEF_Y_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [X_W-1:0]    cfg_width,
  input  logic [Y_W-1:0]    cfg_height,
  input  logic              cfg_wrap,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_done;
  logic              w_done_nxt;

  // Shadow copy of the configuration, frozen for the whole walk.
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_stride;
  logic [X_W-1:0]    r_width;
  logic [Y_W-1:0]    r_height;
  logic              r_wrap;

  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_addr;

  logic [X_W-1:0]    w_x;
  logic [Y_W-1:0]    w_y;
  logic              w_x_tc;
  logic              w_y_tc;
  logic              w_run;
  logic              w_xfer;
  logic              w_eol;
  logic              w_eof;
  logic              w_cfg_ok;
  logic              w_start_go;

  assign w_run      = (r_state == ST_RUN);
  assign w_xfer     = w_run & addr_ready;
  assign w_eol      = w_run & w_x_tc;
  assign w_eof      = w_eol & w_y_tc;
  assign w_cfg_ok   = (cfg_width != '0) && (cfg_height != '0);
  assign w_start_go = !w_run && start && !abort && w_cfg_ok;

  wrap_counter #(.W(X_W)) u_x_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_start_go),
    .inc   (w_xfer),
    .tc    (r_width - X_W'(1)),
    .count (w_x),
    .at_tc (w_x_tc)
  );

  wrap_counter #(.W(Y_W)) u_y_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_start_go),
    .inc   (w_xfer & w_eol),
    .tc    (r_height - Y_W'(1)),
    .count (w_y),
    .at_tc (w_y_tc)
  );

  // State and done-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next state: abort dominates; a degenerate start or the last beat of a
  // non-wrapping frame produces the one-cycle done pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else if (r_state == ST_IDLE) begin
      if (start) begin
        if (w_cfg_ok) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_done_nxt = 1'b1;
        end
      end
    end else begin
      if (w_xfer && w_eof && !r_wrap) begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
      end
    end
  end

  // Shadow config capture and address/row-base arithmetic (modulo 2^ADDR_W).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base     <= '0;
      r_stride   <= '0;
      r_width    <= '0;
      r_height   <= '0;
      r_wrap     <= 1'b0;
      r_row_base <= '0;
      r_addr     <= '0;
    end else if (w_start_go) begin
      r_base     <= cfg_base;
      r_stride   <= cfg_stride;
      r_width    <= cfg_width;
      r_height   <= cfg_height;
      r_wrap     <= cfg_wrap;
      r_row_base <= cfg_base;
      r_addr     <= cfg_base;
    end else if (w_xfer) begin
      if (w_eof) begin
        r_row_base <= r_base;
        r_addr     <= r_base;
      end else if (w_eol) begin
        r_row_base <= r_row_base + r_stride;
        r_addr     <= r_row_base + r_stride;
      end else begin
        r_addr     <= r_addr + ADDR_W'(1);
      end
    end
  end

  // Beat fields read as zero whenever no walk is in progress.
  assign addr_valid = w_run;
  assign busy       = w_run;
  assign addr       = w_run ? r_addr : '0;
  assign x          = w_run ? w_x : '0;
  assign y          = w_run ? w_y : '0;
  assign eol        = w_eol;
  assign eof        = w_eof;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_raster_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_raster_addr_gen
// Description : Self-checking bench for raster_addr_gen: table of frame
//               walks plus directed multi-cycle corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_raster_addr_gen;

  localparam int AW = 16;
  localparam int XW = 10;
  localparam int YW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] cfg_base;
  logic [AW-1:0] cfg_stride;
  logic [XW-1:0] cfg_width;
  logic [YW-1:0] cfg_height;
  logic          cfg_wrap;
  logic          addr_valid;
  logic          addr_ready;
  logic [AW-1:0] addr;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          eol;
  logic          eof;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  raster_addr_gen #(.ADDR_W(AW), .X_W(XW), .Y_W(YW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .cfg_base   (cfg_base),
    .cfg_stride (cfg_stride),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_wrap   (cfg_wrap),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr       (addr),
    .x          (x),
    .y          (y),
    .eol        (eol),
    .eof        (eof),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      base;
    logic [15:0]      stride;
    logic [9:0]       w;
    logic [9:0]       h;
    int               ready_mode;
    int               nbeats;
    logic [7:0][15:0] exp_addr;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm, input logic exp_done);
    chk({nm, " valid"}, 32'(addr_valid), 32'd0);
    chk({nm, " busy"},  32'(busy),       32'd0);
    chk({nm, " addr"},  32'(addr),       32'd0);
    chk({nm, " x"},     32'(x),          32'd0);
    chk({nm, " y"},     32'(y),          32'd0);
    chk({nm, " eol"},   32'(eol),        32'd0);
    chk({nm, " eof"},   32'(eof),        32'd0);
    chk({nm, " done"},  32'(done),       32'(exp_done));
  endtask

  // Walk one non-wrapping frame from the table; every presented beat is
  // compared to the expected beat index, so held beats are checked too.
  task automatic run_vec(input int id, input vec_t v);
    int   idx;
    int   cyc;
    int   xe;
    int   ye;
    logic rdy;
    logic exp_eol;
    idx        = 0;
    cyc        = 0;
    cfg_base   = v.base;
    cfg_stride = v.stride;
    cfg_width  = v.w;
    cfg_height = v.h;
    cfg_wrap   = 1'b0;
    addr_ready = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    while (idx < v.nbeats && cyc < 100) begin
      rdy = (v.ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      addr_ready = rdy;
      xe      = idx % int'(v.w);
      ye      = idx / int'(v.w);
      exp_eol = (xe == int'(v.w) - 1);
      chk($sformatf("v%0d b%0d valid", id, idx), 32'(addr_valid), 32'd1);
      chk($sformatf("v%0d b%0d addr", id, idx), 32'(addr), 32'(v.exp_addr[idx]));
      chk($sformatf("v%0d b%0d x", id, idx), 32'(x), 32'(xe));
      chk($sformatf("v%0d b%0d y", id, idx), 32'(y), 32'(ye));
      chk($sformatf("v%0d b%0d eol", id, idx), 32'(eol), 32'(exp_eol));
      chk($sformatf("v%0d b%0d eof", id, idx), 32'(eof),
          32'(exp_eol && (ye == int'(v.h) - 1)));
      chk($sformatf("v%0d b%0d done", id, idx), 32'(done), 32'd0);
      if (rdy) idx++;
      tick();
      cyc++;
    end
    chk($sformatf("v%0d beats before timeout", id), 32'(idx), 32'(v.nbeats));
    addr_ready = 1'b0;
    chk($sformatf("v%0d end valid", id), 32'(addr_valid), 32'd0);
    chk($sformatf("v%0d end busy", id), 32'(busy), 32'd0);
    chk($sformatf("v%0d end done", id), 32'(done), 32'd1);
    tick();
    chk($sformatf("v%0d done width", id), 32'(done), 32'd0);
  endtask

  initial begin
    logic [15:0] wseq[4];

    vecs[0] = '{16'h0100, 16'd8, 10'd3, 10'd2, 0, 6,
                {16'h0, 16'h0, 16'h010A, 16'h0109, 16'h0108, 16'h0102, 16'h0101, 16'h0100}};
    vecs[1] = '{16'h0100, 16'd8, 10'd3, 10'd2, 1, 6,
                {16'h0, 16'h0, 16'h010A, 16'h0109, 16'h0108, 16'h0102, 16'h0101, 16'h0100}};
    vecs[2] = '{16'hFFFE, 16'd1, 10'd4, 10'd1, 0, 4,
                {16'h0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE}};
    vecs[3] = '{16'h0020, 16'h0010, 10'd1, 10'd3, 1, 3,
                {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0040, 16'h0030, 16'h0020}};
    wseq = '{16'h0010, 16'h0011, 16'h0014, 16'h0015};

    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    cfg_base   = '0;
    cfg_stride = '0;
    cfg_width  = '0;
    cfg_height = '0;
    cfg_wrap   = 1'b0;
    addr_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk_idle("reset", 1'b0);

    for (int i = 0; i < 4; i++) begin
      run_vec(i, vecs[i]);
    end

    // Continuous mode: no bubble and no done across frame boundaries.
    cfg_base   = 16'h0010;
    cfg_stride = 16'd4;
    cfg_width  = 10'd2;
    cfg_height = 10'd2;
    cfg_wrap   = 1'b1;
    addr_ready = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wrap c%0d valid", i), 32'(addr_valid), 32'd1);
      chk($sformatf("wrap c%0d addr", i), 32'(addr), 32'(wseq[i % 4]));
      chk($sformatf("wrap c%0d eof", i), 32'(eof), 32'(i % 4 == 3));
      chk($sformatf("wrap c%0d done", i), 32'(done), 32'd0);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("wrap abort", 1'b0);
    tick();
    chk("wrap abort later done", 32'(done), 32'd0);
    cfg_wrap = 1'b0;

    // Degenerate geometry: done pulse only.
    cfg_width  = 10'd0;
    cfg_height = 10'd2;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk_idle("w0 start", 1'b1);
    tick();
    chk_idle("w0 after", 1'b0);
    cfg_width  = 10'd2;
    cfg_height = 10'd0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk("h0 done", 32'(done), 32'd1);
    chk("h0 valid", 32'(addr_valid), 32'd0);
    tick();

    // Abort on the second beat, then restart with a new configuration.
    cfg_base   = 16'h0200;
    cfg_stride = 16'h0010;
    cfg_width  = 10'd4;
    cfg_height = 10'd4;
    addr_ready = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk("abort b1 addr", 32'(addr), 32'h0200);
    tick();
    chk("abort b2 addr", 32'(addr), 32'h0201);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort next", 1'b0);
    tick();
    chk("abort no done", 32'(done), 32'd0);
    cfg_base   = 16'h0300;
    cfg_stride = 16'h0020;
    cfg_width  = 10'd2;
    cfg_height = 10'd1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk("restart addr", 32'(addr), 32'h0300);
    chk("restart x", 32'(x), 32'd0);
    chk("restart valid", 32'(addr_valid), 32'd1);
    tick();
    chk("restart b2 addr", 32'(addr), 32'h0301);
    chk("restart b2 eof", 32'(eof), 32'd1);
    tick();
    chk("restart done", 32'(done), 32'd1);
    chk("restart end valid", 32'(addr_valid), 32'd0);

    // Start and cfg changes during RUN are ignored; then reset mid-frame.
    cfg_base   = 16'h0100;
    cfg_stride = 16'd8;
    cfg_width  = 10'd3;
    cfg_height = 10'd2;
    addr_ready = 1'b0;
    start      = 1'b1;
    tick();
    start = 1'b0;
    chk("run hold addr", 32'(addr), 32'h0100);
    tick();
    chk("run hold addr2", 32'(addr), 32'h0100);
    start      = 1'b1;
    cfg_base   = 16'h0500;
    cfg_width  = 10'd1;
    addr_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("run start ignored addr", 32'(addr), 32'h0101);
    chk("run start ignored x", 32'(x), 32'd1);
    tick();
    chk("run cfg frozen addr", 32'(addr), 32'h0102);
    chk("run cfg frozen eol", 32'(eol), 32'd1);
    tick();
    chk("run row2 addr", 32'(addr), 32'h0108);
    chk("run row2 y", 32'(y), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("mid reset", 1'b0);
    tick();
    chk("mid reset no done", 32'(done), 32'd0);

    // Abort wins over a simultaneous start.
    cfg_width  = 10'd3;
    start      = 1'b1;
    abort      = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk_idle("abort+start", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/raster_addr_gen.md
# raster_addr_gen

Parametrised 2-D raster address generator for the image buffers: on a start pulse it walks a rectangular window (width × height pixels, row stride, base address) and emits one memory address per accepted beat over a valid/ready handshake. It succeeds the plain increment-on-enable address counter. It sits between the capture/processing control FSMs and the frame BRAM address ports. It adds window geometry, backpressure, row/frame markers, continuous (wrap) mode and abort.

## Interface
Parameters:
- ADDR_W, 16, address width; all address arithmetic is modulo 2^ADDR_W
- X_W, 10, width of column counter and cfg_width
- Y_W, 10, width of row counter and cfg_height

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle request; honoured only in IDLE
- abort  in  1  terminate walk; priority over everything but reset
- cfg_base  in  ADDR_W  address of pixel (0,0)
- cfg_stride  in  ADDR_W  address distance between row starts
- cfg_width  in  X_W  pixels per row
- cfg_height  in  Y_W  rows per frame
- cfg_wrap  in  1  1 = restart frame after last beat; 0 = stop
- addr_valid  out  1  addr/x/y/eol/eof valid
- addr_ready  in  1  consumer accepts current beat
- addr  out  ADDR_W  current address
- x  out  X_W  current column
- y  out  Y_W  current row
- eol  out  1  current beat is last of its row
- eof  out  1  current beat is last of frame
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse after final beat of a non-wrapping frame

## Operation
- States: IDLE, RUN. Reset → IDLE; all outputs 0.
- IDLE: start=1 with cfg_width≠0 and cfg_height≠0 → latch all cfg_* into shadow registers, x=0, y=0, row_base=addr=cfg_base, RUN.
- start with zero width or height: no beats; done pulses next cycle; stay IDLE.
- cfg_* changes after start are ignored until the next start.
- RUN: addr_valid=1. Beat transfers when addr_valid & addr_ready. Without a transfer, addr/x/y/eol/eof hold.
- On a transfer:
  - x < w−1: x+1, addr+1.
  - Else (eol): x=0, y+1, row_base += stride, addr = row_base + stride.
- eol = (x==w−1). eof = eol & (y==h−1). Both are combinational from registered x/y and shadow config.
- Transfer with eof and wrap=1: x=y=0, addr=row_base=base. Stays in RUN with no bubble. No done pulse.
- Transfer with eof and wrap=0: → IDLE, addr_valid=0 next cycle, done=1 for exactly that cycle.
- start in RUN is ignored.
- abort=1 in any state: → IDLE next cycle, valid=0, no done. A beat presented in the abort cycle counts as transferred if ready=1, but no further beat follows. abort and start in the same cycle: abort wins.
- Address overflow wraps silently modulo 2^ADDR_W.

## Timing
- start at edge N → addr_valid=1, addr=base at N+1 (1-cycle latency).
- Sustained throughput is 1 beat/cycle while addr_ready=1, including across row and frame boundaries.
- Last beat accepted at edge M (wrap=0) → at M+1: valid=0, busy=0, done=1. At M+2: done=0. A new start is accepted at M+1.
- reset mid-frame → IDLE next edge; outputs 0; no done.

## Structure
- Shared package raster_pkg holds the state enum (IDLE, RUN) and the default widths ADDR_W, X_W, Y_W.
- One natural sub-module: wrap_counter. It is a parametrised up-counter with clr, inc, a terminal-count input and a tc output. It is instantiated twice, for x (tc=w−1) and for y (tc=h−1).
- The address/row_base adders and the handshake FSM live in the top level.

## Test plan
- base=0x0100, stride=8, w=3, h=2, wrap=0, ready=1: addrs 0x100,101,102,108,109,10A on consecutive cycles. eol on beats 3 and 6, eof on beat 6, done one cycle after beat 6.
- Same config with ready toggled 1,0,0,1,…: every address held stable while ready=0. Sequence and count are identical to the previous case, with no duplicates or skips.
- wrap=1, w=2, h=2, base=0x10, stride=4, ready=1 for 10 cycles: 0x10,11,14,15,10,11,… with no bubble and no done pulse.
- base=0xFFFE, stride=1, w=4, h=1: addrs 0xFFFE, 0xFFFF, 0x0000, 0x0001, then done.
- abort asserted on the 2nd beat of a w=4, h=4 walk: valid=0 on the next cycle and no done. A subsequent start with new config begins at the new base.
- Edge cases:
  - start with w=0: done pulses, no valid.
  - start during RUN: ignored.
  - reset mid-frame: all outputs 0 next cycle.
